// File: rtl/dreg_write_arbiter.sv
// Round-robin arbiter that sequences single-cycle writes from N_REQ requesters
// into one shared enable register. Each write runs IDLE -> WRITE -> ACK.
module dreg_write_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 4,
  parameter int CW    = 8
) (
  input  logic                       clk,
  input  logic                       rest,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*DW-1:0]        wdata,
  output logic [DW-1:0]              reg_d,
  output logic                       reg_en,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           ack,
  output logic [$clog2(N_REQ)-1:0]   last_id,
  output logic                       busy,
  output logic [CW-1:0]              wr_count
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    win_q, win_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [DW-1:0]    reg_d_q, reg_d_d;
  logic             reg_en_q, reg_en_d;
  logic             busy_q, busy_d;
  logic [IW-1:0]    last_id_q, last_id_d;
  logic [CW-1:0]    wr_count_q, wr_count_d;

  // cand_idx[k] is the requester examined k-th when searching upward from ptr.
  logic [IW-1:0]    cand_idx [N_REQ];
  logic             win_found;
  logic [IW-1:0]    win_idx;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    assign cand_idx[gi] = IW'((32'(ptr_q) + gi) % N_REQ);
  end

  // Scanning from the far end means the nearest requester to ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[cand_idx[k]]) begin
        win_found = 1'b1;
        win_idx   = cand_idx[k];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    gnt_d      = gnt_q;
    ack_d      = '0;
    reg_d_d    = reg_d_q;
    reg_en_d   = 1'b0;
    busy_d     = busy_q;
    last_id_d  = last_id_q;
    wr_count_d = wr_count_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d  = WRITE;
          win_d    = win_idx;
          gnt_d    = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
          reg_d_d  = wdata[win_idx*DW +: DW];
          reg_en_d = 1'b1;
          busy_d   = 1'b1;
        end
      end
      WRITE: begin
        state_d = ACK;
        ack_d   = gnt_q;
      end
      ACK: begin
        state_d    = IDLE;
        gnt_d      = '0;
        busy_d     = 1'b0;
        last_id_d  = win_q;
        wr_count_d = wr_count_q + 1'b1;
        ptr_d      = (win_q == IW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      gnt_q      <= '0;
      ack_q      <= '0;
      reg_d_q    <= '0;
      reg_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      last_id_q  <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      reg_d_q    <= reg_d_d;
      reg_en_q   <= reg_en_d;
      busy_q     <= busy_d;
      last_id_q  <= last_id_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign reg_d    = reg_d_q;
  assign reg_en   = reg_en_q;
  assign gnt      = gnt_q;
  assign ack      = ack_q;
  assign last_id  = last_id_q;
  assign busy     = busy_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_dreg_write_arbiter.sv
// Randomized and directed bench for dreg_write_arbiter; expected outputs come
// from a transaction schedule built whenever a grant is predicted.
module tb_dreg_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            rest = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [DW-1:0]   reg_d;
  logic            reg_en;
  logic [N-1:0]    gnt;
  logic [N-1:0]    ack;
  logic [1:0]      last_id;
  logic            busy;
  logic [CW-1:0]   wr_count;
  logic [DW-1:0]   ext_q = '0;

  dreg_write_arbiter #(.N_REQ(N), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rest(rest), .req(req), .wdata(wdata),
    .reg_d(reg_d), .reg_en(reg_en), .gnt(gnt), .ack(ack),
    .last_id(last_id), .busy(busy), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  // The shared register itself: not touched by the arbiter reset.
  always @(posedge clk) if (reg_en) ext_q <= reg_d;

  typedef struct {
    logic          en;
    logic [DW-1:0] d;
    logic [N-1:0]  g;
    logic [N-1:0]  a;
    logic          busy;
    logic          act;
    logic          done;
    int            w;
  } exp_t;

  exp_t          cur;
  exp_t          sched[$];
  int            m_ptr, m_last, m_count;
  logic [DW-1:0] m_d, m_ext;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t idle_e(input logic [DW-1:0] d);
    exp_t e;
    e.en = 1'b0; e.d = d; e.g = '0; e.a = '0; e.busy = 1'b0;
    e.act = 1'b0; e.done = 1'b0; e.w = 0;
    return e;
  endfunction

  task automatic model_reset();
    sched.delete();
    m_ptr = 0; m_last = 0; m_count = 0; m_d = '0;
    cur = idle_e('0);
  endtask

  task automatic compare();
    check("reg_en",   reg_en,   cur.en);
    check("reg_d",    reg_d,    cur.d);
    check("gnt",      gnt,      cur.g);
    check("ack",      ack,      cur.a);
    check("busy",     busy,     cur.busy);
    check("last_id",  last_id,  m_last);
    check("wr_count", wr_count, m_count);
    check("ext_reg",  ext_q,    m_ext);
    check("gnt_onehot", $onehot0(gnt), 1);
    check("ack_in_gnt", ack & ~gnt, 0);
    if (cur.a != '0)
      $display("write id=%0d data=%h count_before=%0d", cur.w, cur.d, m_count);
  endtask

  // Predict what the outputs will be after the next rising edge.
  task automatic advance_model();
    exp_t e;
    int   w;
    logic [N-1:0] gm;
    if (cur.en) m_ext = cur.d;
    if (cur.done) begin
      m_last  = cur.w;
      m_count = (m_count + 1) % (1 << CW);
      m_ptr   = (cur.w + 1) % N;
    end
    if (sched.size() > 0) begin
      cur = sched.pop_front();
    end else if (!cur.act && req != '0) begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      m_d = wdata[w*DW +: DW];
      gm = '0; gm[w] = 1'b1;
      e.en = 1'b1; e.d = m_d; e.g = gm; e.a = '0; e.busy = 1'b1;
      e.act = 1'b1; e.done = 1'b0; e.w = w;
      sched.push_back(e);
      e.en = 1'b0; e.a = gm; e.done = 1'b1;
      sched.push_back(e);
      cur = sched.pop_front();
    end else begin
      cur = idle_e(m_d);
    end
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic [N*DW-1:0] wd);
    @(negedge clk);
    compare();
    req = r;
    wdata = wd;
    advance_model();
  endtask

  // Assert reset between edges, hold n further cycles, release with r/wd driven.
  task automatic do_reset(input int n, input logic [N-1:0] r, input logic [N*DW-1:0] wd);
    @(negedge clk);
    compare();
    rest = 1'b0;
    model_reset();
    req = r;
    wdata = wd;
    #1;
    compare();
    repeat (n) begin
      @(negedge clk);
      compare();
    end
    rest = 1'b1;
    advance_model();
  endtask

  logic [N-1:0]    rr;
  logic [N*DW-1:0] rw;

  initial begin
    m_ext = '0;
    model_reset();
    #1 rest = 1'b0;
    req = 4'b1111;

    do_reset(3, 4'b1111, 16'h4321);
    repeat (6) cycle(4'b1111, 16'h4321);
    repeat (3) cycle(4'b0000, 16'h4321);

    cycle(4'b0100, 16'h0A00);
    repeat (4) cycle(4'b0000, 16'h0A00);

    for (int i = 0; i < 15; i++) begin
      rw = N*DW'($urandom());
      cycle(4'b1111, rw);
    end
    repeat (3) cycle(4'b0000, 16'h0000);

    cycle(4'b0100, 16'h0B00);
    repeat (3) cycle(4'b0000, 16'h0B00);
    repeat (6) cycle(4'b1001, 16'hC00D);
    repeat (3) cycle(4'b0000, 16'hC00D);

    cycle(4'b0010, 16'h0050);
    cycle(4'b0000, 16'h00F0);
    cycle(4'b0000, 16'h00F0);
    cycle(4'b0000, 16'h00F0);
    cycle(4'b1000, 16'h7000);
    cycle(4'b0000, 16'h7000);
    do_reset(1, 4'b1111, 16'h1234);
    repeat (4) cycle(4'b0000, 16'h1234);

    for (int i = 0; i < 770; i++) begin
      rw = N*DW'($urandom());
      cycle(4'b0001, rw);
    end

    for (int i = 0; i < 2500; i++) begin
      rr = N'($urandom());
      rw = N*DW'($urandom());
      if ($urandom_range(0, 199) == 0) do_reset($urandom_range(0, 2), rr, rw);
      else cycle(rr, rw);
    end

    @(negedge clk);
    compare();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
